line_arbiter: RTL



---
 rtl/line_arbiter_if.sv | 38 +++
 rtl/line_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/line_arbiter_if.sv
// Bundle of the I-cache, D-cache and adaptor-side signals around the line arbiter.
// The slave modport is the arbiter's view; master is the caches/adaptor view.
interface line_arbiter_if #(
  parameter int s_offset = 5
);
  localparam int LW = (2**s_offset)*8;

  logic          i_read;
  logic [31:0]   i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;

  logic          d_read;
  logic          d_write;
  logic [31:0]   d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;

  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  logic [1:0]    owner;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata, owner
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata, owner
  );
endinterface

// File: rtl/line_arbiter.sv
// Shares one cacheline adaptor port between I-cache and D-cache. D has fixed
// priority, but I wins once STARVE_LIMIT D grants have gone by while it waited.
module line_arbiter #(
  parameter int s_offset     = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  line_arbiter_if.slave bus
);
  localparam int LW = (2**s_offset)*8;
  localparam int CW = $clog2(STARVE_LIMIT+1);
  localparam logic [CW-1:0] LIMIT     = CW'(STARVE_LIMIT);
  localparam logic [31:0]   ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, RESP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_starve;
  logic          r_mem_read, r_mem_write;
  logic [31:0]   r_mem_address;
  logic [LW-1:0] r_mem_wdata;
  logic [LW-1:0] r_i_rdata, r_d_rdata;
  logic          r_i_resp, r_d_resp;
  logic [1:0]    r_owner;

  logic w_d_req, w_i_wins;

  assign w_d_req  = bus.d_read | bus.d_write;
  // I only beats a pending D request once the starvation budget is spent.
  assign w_i_wins = bus.i_read & (~w_d_req | (r_starve >= LIMIT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_starve      <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_i_rdata     <= '0;
      r_d_rdata     <= '0;
      r_i_resp      <= 1'b0;
      r_d_resp      <= 1'b0;
      r_owner       <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_d_req && !w_i_wins) begin
            r_state       <= bus.d_write ? D_WR : D_RD;
            r_mem_write   <= bus.d_write;
            r_mem_read    <= ~bus.d_write;
            r_mem_address <= bus.d_address & ADDR_MASK;
            if (bus.d_write) r_mem_wdata <= bus.d_wdata;
            r_owner       <= 2'd2;
            if (bus.i_read && r_starve < LIMIT) r_starve <= r_starve + CW'(1);
          end else if (bus.i_read) begin
            r_state       <= I_RD;
            r_mem_read    <= 1'b1;
            r_mem_address <= bus.i_address & ADDR_MASK;
            r_owner       <= 2'd1;
            r_starve      <= '0;
          end
        end
        I_RD, D_RD, D_WR: begin
          if (bus.mem_resp) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_state     <= RESP;
            if (r_state == I_RD) begin
              r_i_rdata <= bus.mem_rdata;
              r_i_resp  <= 1'b1;
            end else begin
              if (r_state == D_RD) r_d_rdata <= bus.mem_rdata;
              r_d_resp <= 1'b1;
            end
          end
        end
        RESP: begin
          r_i_resp <= 1'b0;
          r_d_resp <= 1'b0;
          r_owner  <= 2'd0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.i_rdata     = r_i_rdata;
  assign bus.d_rdata     = r_d_rdata;
  assign bus.i_resp      = r_i_resp;
  assign bus.d_resp      = r_d_resp;
  assign bus.owner       = r_owner;
endmodule
